// File: rtl/rename_alloc_if.sv
// Rename/allocate stage port bundle: decode-side handshake, ROB dispatch fields,
// retire release strobes and free-list status.
interface rename_alloc_if #(
  parameter int unsigned PREG_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic              out_valid;
  logic              out_stall;
  logic [31:0]       out_pc;
  logic [PREG_W-1:0] out_prs1;
  logic [PREG_W-1:0] out_prs2;
  logic [PREG_W-1:0] out_prd;
  logic [PREG_W-1:0] out_old_prd;
  logic              free_en_0;
  logic              free_en_1;
  logic [PREG_W-1:0] free_reg_0;
  logic [PREG_W-1:0] free_reg_1;
  logic [PREG_W:0]   free_count;
  logic              dbl_free_err;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rd, out_stall,
           free_en_0, free_en_1, free_reg_0, free_reg_1,
    input  in_ready, out_valid, out_pc, out_prs1, out_prs2, out_prd,
           out_old_prd, free_count, dbl_free_err
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rd, out_stall,
           free_en_0, free_en_1, free_reg_0, free_reg_1,
    output in_ready, out_valid, out_pc, out_prs1, out_prs2, out_prd,
           out_old_prd, free_count, dbl_free_err
  );
endinterface

// File: rtl/rename_alloc.sv
// Register rename + physical-register allocation ahead of the ROB.
// Optional double-free detection is enabled by defining RENAME_DBL_FREE_CHECK_EN.
module rename_alloc #(
  parameter int unsigned NUM_ARCH = 32,
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned FL_DEPTH = NUM_PHYS - NUM_ARCH
) (
  input  logic         clk,
  input  logic         rst,
  rename_alloc_if.slave io
);
  localparam int unsigned HW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int unsigned CW = PREG_W + 1;

  typedef logic [PREG_W-1:0] preg_t;

  preg_t          rat_q [NUM_ARCH];
  preg_t          rat_d [NUM_ARCH];
  preg_t          fl_q  [FL_DEPTH];
  preg_t          fl_d  [FL_DEPTH];
  logic [HW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           out_valid_q, out_valid_d;
  logic [31:0]    out_pc_q, out_pc_d;
  preg_t          out_prs1_q, out_prs1_d, out_prs2_q, out_prs2_d;
  preg_t          out_prd_q, out_prd_d, out_old_prd_q, out_old_prd_d;

  logic           hold, rdy, accept, pop;
  logic           push0_req, push1_req, push0, push1;
  preg_t          pop_reg;

`ifdef RENAME_DBL_FREE_CHECK_EN
  logic [NUM_PHYS-1:0] in_fl_q, in_fl_d;
  logic                dbl_err_q, dbl_err_d;
`endif

  function automatic logic [HW-1:0] wrap_inc(input logic [HW-1:0] idx);
    return (32'(idx) == FL_DEPTH - 1) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    hold      = out_valid_q && io.out_stall;
    rdy       = !hold && (count_q != '0 || io.in_rd == '0);
    accept    = io.in_valid && rdy;
    pop       = accept && (io.in_rd != '0);
    pop_reg   = fl_q[head_q];
    push0_req = io.free_en_0 && (io.free_reg_0 != '0);
    push1_req = io.free_en_1 && (io.free_reg_1 != '0);

`ifdef RENAME_DBL_FREE_CHECK_EN
    dbl_err_d = dbl_err_q;
    in_fl_d   = in_fl_q;
    push0     = push0_req && !in_fl_q[io.free_reg_0];
    push1     = push1_req && !in_fl_q[io.free_reg_1] &&
                !(push0_req && (io.free_reg_1 == io.free_reg_0));
    if ((push0_req && !push0) || (push1_req && !push1)) dbl_err_d = 1'b1;
`else
    push0 = push0_req;
    push1 = push1_req;
`endif

    // Capacity is judged on the registered count, independent of this cycle's pop.
    if (count_q == CW'(FL_DEPTH)) begin
      push0 = 1'b0;
      push1 = 1'b0;
    end else if ((count_q == CW'(FL_DEPTH - 1)) && push0) begin
      push1 = 1'b0;
    end

`ifdef RENAME_DBL_FREE_CHECK_EN
    if (pop)   in_fl_d[pop_reg]       = 1'b0;
    if (push0) in_fl_d[io.free_reg_0] = 1'b1;
    if (push1) in_fl_d[io.free_reg_1] = 1'b1;
`endif

    fl_d   = fl_q;
    tail_d = tail_q;
    if (push0) begin
      fl_d[tail_d] = io.free_reg_0;
      tail_d       = wrap_inc(tail_d);
    end
    if (push1) begin
      fl_d[tail_d] = io.free_reg_1;
      tail_d       = wrap_inc(tail_d);
    end
    head_d  = pop ? wrap_inc(head_q) : head_q;
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);

    rat_d = rat_q;
    if (pop) rat_d[io.in_rd] = pop_reg;

    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_prs1_d    = out_prs1_q;
    out_prs2_d    = out_prs2_q;
    out_prd_d     = out_prd_q;
    out_old_prd_d = out_old_prd_q;
    if (!hold) begin
      out_valid_d = accept;
      if (accept) begin
        out_pc_d      = io.in_pc;
        out_prs1_d    = rat_q[io.in_rs1];
        out_prs2_d    = rat_q[io.in_rs2];
        out_prd_d     = pop ? pop_reg : '0;
        out_old_prd_d = pop ? rat_q[io.in_rd] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) rat_q[i] <= PREG_W'(i);
      for (int unsigned i = 0; i < FL_DEPTH; i++) fl_q[i] <= PREG_W'(NUM_PHYS - FL_DEPTH + i);
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= CW'(FL_DEPTH);
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_prs1_q    <= '0;
      out_prs2_q    <= '0;
      out_prd_q     <= '0;
      out_old_prd_q <= '0;
    end else begin
      rat_q         <= rat_d;
      fl_q          <= fl_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_prs1_q    <= out_prs1_d;
      out_prs2_q    <= out_prs2_d;
      out_prd_q     <= out_prd_d;
      out_old_prd_q <= out_old_prd_d;
    end
  end

`ifdef RENAME_DBL_FREE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) in_fl_q[i] <= (i >= NUM_PHYS - FL_DEPTH);
      dbl_err_q <= 1'b0;
    end else begin
      in_fl_q   <= in_fl_d;
      dbl_err_q <= dbl_err_d;
    end
  end
  assign io.dbl_free_err = dbl_err_q;
`else
  assign io.dbl_free_err = 1'b0;
`endif

  assign io.in_ready    = rdy;
  assign io.out_valid   = out_valid_q;
  assign io.out_pc      = out_pc_q;
  assign io.out_prs1    = out_prs1_q;
  assign io.out_prs2    = out_prs2_q;
  assign io.out_prd     = out_prd_q;
  assign io.out_old_prd = out_old_prd_q;
  assign io.free_count  = count_q;
endmodule
